// File: rtl/collision_monitor_pkg.sv
// Shared game package.
// Holds the game FSM state encoding and the default coordinate width.
// The collision monitor and its overlap sub-module both import it.
package collision_monitor_pkg;

  // Default width of every coordinate and size on the video grid.
  localparam int COORD_W_DEFAULT = 9;

  // Game FSM states. The collision monitor only counts and confirms while in RUN.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2,
    WIN  = 2'd3
  } state_t;

endpackage

// File: rtl/collision_monitor_box_overlap.sv
// box_overlap: purely combinational overlap test between two axis-aligned boxes.
// Boxes are half-open on both axes: [x, x+w) x [y, y+h).
// Ports:
//   a_x, a_y, a_w, a_h : box A, COORD_W+1 bits. The extra bit lets a shrunk or offset box fit.
//   b_x, b_y, b_w, b_h : box B, COORD_W+1 bits.
//   overlap            : 1 when the two boxes share at least one pixel.
// The end coordinates are formed one bit wider than the ports, so the sums cannot wrap.
// A box with zero width or zero height never overlaps.
module box_overlap #(
  parameter int COORD_W = 9
) (
  input  logic [COORD_W:0] a_x,
  input  logic [COORD_W:0] a_y,
  input  logic [COORD_W:0] a_w,
  input  logic [COORD_W:0] a_h,
  input  logic [COORD_W:0] b_x,
  input  logic [COORD_W:0] b_y,
  input  logic [COORD_W:0] b_w,
  input  logic [COORD_W:0] b_h,
  output logic             overlap
);

  logic [COORD_W+1:0] a_x_end, a_y_end, b_x_end, b_y_end;

  assign a_x_end = {1'b0, a_x} + {1'b0, a_w};
  assign a_y_end = {1'b0, a_y} + {1'b0, a_h};
  assign b_x_end = {1'b0, b_x} + {1'b0, b_w};
  assign b_y_end = {1'b0, b_y} + {1'b0, b_h};

  assign overlap = ({1'b0, a_x} < b_x_end) && ({1'b0, b_x} < a_x_end) &&
                   ({1'b0, a_y} < b_y_end) && ({1'b0, b_y} < a_y_end);

endmodule

// File: rtl/collision_monitor.sv
// collision_monitor: frame-synchronous collision monitor for the dino runner.
// On each frame_tick in RUN, it compares a shrunk dino hitbox against N_OBS obstacle boxes.
// A slot must overlap for CONFIRM_FRAMES consecutive ticks before a hit is reported.
// The report stays latched until clear is asserted or the game leaves RUN.
// Ports:
//   clk, reset (async, active-low)
//   state           : game FSM state
//   frame_tick      : one-cycle sampling strobe per frame
//   clear           : synchronous clear of the latch and the counters
//   dino_*          : dino box (top-left origin, y grows downward)
//   obs_*           : packed obstacle boxes; slot i is at [i*COORD_W +: COORD_W]
//   obs_valid       : per-slot live flag
//   overlap_now     : registered raw per-slot overlap from the last tick taken
//   collision       : sticky confirmed collision
//   collision_pulse : one-cycle pulse when collision sets
//   hit_mask        : slots that confirmed on the latching tick
//   hit_index       : lowest set bit of hit_mask
module collision_monitor
  import collision_monitor_pkg::*;
#(
  parameter int COORD_W        = COORD_W_DEFAULT,
  parameter int N_OBS          = 3,
  parameter int CONFIRM_FRAMES = 2,
  parameter int MARGIN         = 1,
  localparam int IDX_W         = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  state_t                   state,
  input  logic                     frame_tick,
  input  logic                     clear,
  input  logic [COORD_W-1:0]       dino_x,
  input  logic [COORD_W-1:0]       dino_y,
  input  logic [COORD_W-1:0]       dino_w,
  input  logic [COORD_W-1:0]       dino_h,
  input  logic [N_OBS*COORD_W-1:0] obs_x,
  input  logic [N_OBS*COORD_W-1:0] obs_y,
  input  logic [N_OBS*COORD_W-1:0] obs_w,
  input  logic [N_OBS*COORD_W-1:0] obs_h,
  input  logic [N_OBS-1:0]         obs_valid,
  output logic [N_OBS-1:0]         overlap_now,
  output logic                     collision,
  output logic                     collision_pulse,
  output logic [N_OBS-1:0]         hit_mask,
  output logic [IDX_W-1:0]         hit_index
);

  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam int BW = COORD_W + 1;
  localparam logic [CW-1:0] CONFIRM_CNT = CW'(CONFIRM_FRAMES);
  localparam logic [BW-1:0] MARGIN_BW   = BW'(MARGIN);
  localparam logic [BW-1:0] MARGIN2_BW  = BW'(2 * MARGIN);

  // Shrunk dino hitbox. The width and height are only meaningful when the box is not empty.
  // Otherwise they may wrap, and hb_empty masks every slot instead.
  logic [BW-1:0] hb_x, hb_y, hb_w, hb_h;
  logic          hb_empty;

  assign hb_empty = ({1'b0, dino_w} <= MARGIN2_BW) || ({1'b0, dino_h} <= MARGIN2_BW);
  assign hb_x     = {1'b0, dino_x} + MARGIN_BW;
  assign hb_y     = {1'b0, dino_y} + MARGIN_BW;
  assign hb_w     = {1'b0, dino_w} - MARGIN2_BW;
  assign hb_h     = {1'b0, dino_h} - MARGIN2_BW;

  logic [N_OBS-1:0] raw_overlap;
  logic [N_OBS-1:0] ov_next;
  logic [N_OBS-1:0] confirm_next;

  logic [N_OBS-1:0] overlap_now_reg;
  logic             collision_reg;
  logic             collision_pulse_reg;
  logic [N_OBS-1:0] hit_mask_reg;
  logic [IDX_W-1:0] hit_index_reg;
  logic [IDX_W-1:0] hit_index_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_OBS; gi++) begin : g_slot
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;

      box_overlap #(.COORD_W(COORD_W)) u_box_overlap (
        .a_x     (hb_x),
        .a_y     (hb_y),
        .a_w     (hb_w),
        .a_h     (hb_h),
        .b_x     ({1'b0, obs_x[gi*COORD_W +: COORD_W]}),
        .b_y     ({1'b0, obs_y[gi*COORD_W +: COORD_W]}),
        .b_w     ({1'b0, obs_w[gi*COORD_W +: COORD_W]}),
        .b_h     ({1'b0, obs_h[gi*COORD_W +: COORD_W]}),
        .overlap (raw_overlap[gi])
      );

      assign ov_next[gi] = raw_overlap[gi] & obs_valid[gi] & ~hb_empty;

      // The streak counter saturates at CONFIRM_CNT. Any non-overlapping tick restarts the streak.
      assign cnt_next = ov_next[gi]
                        ? ((cnt_reg == CONFIRM_CNT) ? CONFIRM_CNT : cnt_reg + CW'(1))
                        : '0;
      assign confirm_next[gi] = (cnt_next == CONFIRM_CNT);

      // The counter freezes while the latch holds, so it does not keep streaking on a dead game.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (clear || (state != RUN)) begin
          cnt_reg <= '0;
        end else if (frame_tick && !collision_reg) begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  // hit_index is the lowest confirming slot. Scanning downward lets the lowest index win.
  always_comb begin
    hit_index_next = '0;
    for (int i = N_OBS - 1; i >= 0; i--) begin
      if (confirm_next[i]) hit_index_next = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overlap_now_reg     <= '0;
      collision_reg       <= 1'b0;
      collision_pulse_reg <= 1'b0;
      hit_mask_reg        <= '0;
      hit_index_reg       <= '0;
    end else begin
      collision_pulse_reg <= 1'b0;
      if (clear) begin
        // A tick in the same cycle is discarded, so overlap_now keeps its last value.
        collision_reg <= 1'b0;
        hit_mask_reg  <= '0;
        hit_index_reg <= '0;
      end else if (state != RUN) begin
        collision_reg <= 1'b0;
        hit_mask_reg  <= '0;
        hit_index_reg <= '0;
        if (frame_tick) overlap_now_reg <= '0;
      end else if (frame_tick) begin
        overlap_now_reg <= ov_next;
        if (!collision_reg && (|confirm_next)) begin
          collision_reg       <= 1'b1;
          collision_pulse_reg <= 1'b1;
          hit_mask_reg        <= confirm_next;
          hit_index_reg       <= hit_index_next;
        end
      end
    end
  end

  assign overlap_now     = overlap_now_reg;
  assign collision       = collision_reg;
  assign collision_pulse = collision_pulse_reg;
  assign hit_mask        = hit_mask_reg;
  assign hit_index       = hit_index_reg;

endmodule

// File: tb/tb_collision_monitor.sv
// Table-driven bench for collision_monitor with default parameters.
// The dino box is (40,100,20,24), so the shrunk hitbox covers x in [41,59) and y in [101,123).
// Fixed obstacle geometry:
//   slot0 y=110 w=10 h=20; slot1 y=105 w=5 h=5; slot2 y=115 w=4 h=4.
// Only the x positions, dino_w, valid, state, tick and clear change from row to row.
module tb_collision_monitor;
  import collision_monitor_pkg::*;

  logic        clk;
  logic        reset;
  state_t      state;
  logic        frame_tick;
  logic        clear;
  logic [8:0]  dino_x, dino_y, dino_w, dino_h;
  logic [26:0] obs_x, obs_y, obs_w, obs_h;
  logic [2:0]  obs_valid;
  logic [2:0]  overlap_now;
  logic        collision;
  logic        collision_pulse;
  logic [2:0]  hit_mask;
  logic [1:0]  hit_index;

  int checks;
  int failures;

  collision_monitor dut (
    .clk             (clk),
    .reset           (reset),
    .state           (state),
    .frame_tick      (frame_tick),
    .clear           (clear),
    .dino_x          (dino_x),
    .dino_y          (dino_y),
    .dino_w          (dino_w),
    .dino_h          (dino_h),
    .obs_x           (obs_x),
    .obs_y           (obs_y),
    .obs_w           (obs_w),
    .obs_h           (obs_h),
    .obs_valid       (obs_valid),
    .overlap_now     (overlap_now),
    .collision       (collision),
    .collision_pulse (collision_pulse),
    .hit_mask        (hit_mask),
    .hit_index       (hit_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    state_t     st;
    logic       tick;
    logic       clr;
    logic [2:0] valid;
    logic [8:0] dw;
    logic [8:0] x0, x1, x2;
    logic [2:0] e_ov;
    logic       e_col;
    logic       e_pls;
    logic [2:0] e_mask;
    logic [1:0] e_idx;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(state_t st, logic tick, logic clr, logic [2:0] valid,
                              logic [8:0] dw, logic [8:0] x0, logic [8:0] x1, logic [8:0] x2,
                              logic [2:0] e_ov, logic e_col, logic e_pls,
                              logic [2:0] e_mask, logic [1:0] e_idx);
    vec_t v;
    v.st = st; v.tick = tick; v.clr = clr; v.valid = valid; v.dw = dw;
    v.x0 = x0; v.x1 = x1; v.x2 = x2;
    v.e_ov = e_ov; v.e_col = e_col; v.e_pls = e_pls; v.e_mask = e_mask; v.e_idx = e_idx;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [2:0] e_ov, input logic e_col, input logic e_pls,
                           input logic [2:0] e_mask, input logic [1:0] e_idx);
    check("overlap_now", idx, 9'(overlap_now), 9'(e_ov));
    check("collision", idx, 9'(collision), 9'(e_col));
    check("collision_pulse", idx, 9'(collision_pulse), 9'(e_pls));
    check("hit_mask", idx, 9'(hit_mask), 9'(e_mask));
    check("hit_index", idx, 9'(hit_index), 9'(e_idx));
  endtask

  task automatic drive(input state_t st, input logic tick, input logic clr, input logic [2:0] valid,
                       input logic [8:0] dw, input logic [8:0] x0, input logic [8:0] x1, input logic [8:0] x2);
    state = st; frame_tick = tick; clear = clr; obs_valid = valid;
    dino_x = 9'd40; dino_y = 9'd100; dino_w = dw; dino_h = 9'd24;
    obs_x = {x2, x1, x0};
    obs_y = {9'd115, 9'd105, 9'd110};
    obs_w = {9'd4, 9'd5, 9'd10};
    obs_h = {9'd4, 9'd5, 9'd20};
  endtask

  task automatic drive_random();
    state = state_t'(2'($urandom));
    frame_tick = 1'($urandom); clear = 1'($urandom);
    dino_x = 9'($urandom); dino_y = 9'($urandom); dino_w = 9'($urandom); dino_h = 9'($urandom);
    obs_x = 27'($urandom); obs_y = 27'($urandom); obs_w = 27'($urandom); obs_h = 27'($urandom);
    obs_valid = 3'($urandom);
  endtask

  task automatic show(input int idx);
    $display("step %0d st=%0d tick=%0b clr=%0b valid=%b ov=%b col=%b pls=%b mask=%b idx=%0d",
             idx, state, frame_tick, clear, obs_valid, overlap_now, collision, collision_pulse,
             hit_mask, hit_index);
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // Confirm after two frames, latch hold, and a pulse that does not re-fire.
    vecs[0]  = mk(RUN,  0, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    vecs[1]  = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b001, 0, 0, 3'b000, 2'd0);
    vecs[2]  = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b001, 1, 1, 3'b001, 2'd0);
    vecs[3]  = mk(RUN,  0, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b001, 1, 0, 3'b001, 2'd0);
    vecs[4]  = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b001, 1, 0, 3'b001, 2'd0);
    vecs[5]  = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd200, 9'd300, 9'd300, 3'b000, 1, 0, 3'b001, 2'd0);
    vecs[6]  = mk(OVER, 0, 0, 3'b001, 9'd20, 9'd200, 9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    // Broken streak.
    vecs[7]  = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b001, 0, 0, 3'b000, 2'd0);
    vecs[8]  = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd200, 9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    vecs[9]  = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b001, 0, 0, 3'b000, 2'd0);
    vecs[10] = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b001, 1, 1, 3'b001, 2'd0);
    vecs[11] = mk(OVER, 1, 0, 3'b001, 9'd20, 9'd55,  9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    // Margin edge and an empty dino box.
    vecs[12] = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd59,  9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    vecs[13] = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd59,  9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    vecs[14] = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd58,  9'd300, 9'd300, 3'b001, 0, 0, 3'b000, 2'd0);
    vecs[15] = mk(RUN,  1, 0, 3'b001, 9'd2,  9'd58,  9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    vecs[16] = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd58,  9'd300, 9'd300, 3'b001, 0, 0, 3'b000, 2'd0);
    vecs[17] = mk(RUN,  1, 0, 3'b001, 9'd2,  9'd58,  9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    vecs[18] = mk(RUN,  1, 0, 3'b001, 9'd20, 9'd200, 9'd300, 9'd300, 3'b000, 0, 0, 3'b000, 2'd0);
    // Simultaneous hits on slots 1 and 2.
    vecs[19] = mk(RUN,  1, 0, 3'b111, 9'd20, 9'd200, 9'd45,  9'd50,  3'b110, 0, 0, 3'b000, 2'd0);
    vecs[20] = mk(RUN,  1, 0, 3'b111, 9'd20, 9'd200, 9'd45,  9'd50,  3'b110, 1, 1, 3'b110, 2'd1);
    vecs[21] = mk(OVER, 0, 0, 3'b111, 9'd20, 9'd200, 9'd45,  9'd50,  3'b110, 0, 0, 3'b000, 2'd0);
    // A clear on the second tick discards that tick and resets the counters.
    vecs[22] = mk(RUN,  1, 0, 3'b111, 9'd20, 9'd200, 9'd45,  9'd50,  3'b110, 0, 0, 3'b000, 2'd0);
    vecs[23] = mk(RUN,  1, 1, 3'b111, 9'd20, 9'd200, 9'd45,  9'd50,  3'b110, 0, 0, 3'b000, 2'd0);
    vecs[24] = mk(RUN,  1, 0, 3'b111, 9'd20, 9'd200, 9'd45,  9'd50,  3'b110, 0, 0, 3'b000, 2'd0);
    vecs[25] = mk(RUN,  1, 0, 3'b111, 9'd20, 9'd200, 9'd45,  9'd50,  3'b110, 1, 1, 3'b110, 2'd1);
    vecs[26] = mk(RUN,  0, 1, 3'b111, 9'd20, 9'd200, 9'd45,  9'd50,  3'b110, 0, 0, 3'b000, 2'd0);
    // obs_valid dropping mid-count restarts the streak.
    vecs[27] = mk(RUN,  1, 0, 3'b100, 9'd20, 9'd200, 9'd45,  9'd50,  3'b100, 0, 0, 3'b000, 2'd0);
    vecs[28] = mk(RUN,  1, 0, 3'b000, 9'd20, 9'd200, 9'd45,  9'd50,  3'b000, 0, 0, 3'b000, 2'd0);
    vecs[29] = mk(RUN,  1, 0, 3'b100, 9'd20, 9'd200, 9'd45,  9'd50,  3'b100, 0, 0, 3'b000, 2'd0);
    vecs[30] = mk(RUN,  1, 0, 3'b100, 9'd20, 9'd200, 9'd45,  9'd50,  3'b100, 1, 1, 3'b100, 2'd2);
    vecs[31] = mk(RUN,  0, 0, 3'b100, 9'd20, 9'd200, 9'd45,  9'd50,  3'b100, 1, 0, 3'b100, 2'd2);

    // Hold reset with random inputs; every output must stay 0.
    reset = 1'b0;
    drive_random();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check_all(-1, 3'b000, 0, 0, 3'b000, 2'd0);
      show(-1);
      drive_random();
    end

    // Release with no ticks; outputs must stay 0.
    drive(RUN, 0, 0, 3'b001, 9'd20, 9'd55, 9'd300, 9'd300);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_all(-2, 3'b000, 0, 0, 3'b000, 2'd0);
      show(-2);
    end

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st, vecs[i].tick, vecs[i].clr, vecs[i].valid, vecs[i].dw,
            vecs[i].x0, vecs[i].x1, vecs[i].x2);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].e_ov, vecs[i].e_col, vecs[i].e_pls, vecs[i].e_mask, vecs[i].e_idx);
      show(i);
    end

    // Asynchronous reset mid-latch: collision is 1 here, and must clear without a clock edge.
    drive(RUN, 0, 0, 3'b100, 9'd20, 9'd200, 9'd45, 9'd50);
    #2;
    reset = 1'b0;
    #1;
    check_all(100, 3'b000, 0, 0, 3'b000, 2'd0);
    show(100);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Asynchronous reset mid-count: the streak must restart after the reset is released.
    drive(RUN, 1, 0, 3'b001, 9'd20, 9'd55, 9'd300, 9'd300);
    @(posedge clk);
    #1;
    check_all(101, 3'b001, 0, 0, 3'b000, 2'd0);
    show(101);
    frame_tick = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all(102, 3'b000, 0, 0, 3'b000, 2'd0);
    show(102);
    @(posedge clk);
    #1;
    reset = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    check_all(103, 3'b001, 0, 0, 3'b000, 2'd0);
    show(103);
    @(posedge clk);
    #1;
    check_all(104, 3'b001, 1, 1, 3'b001, 2'd0);
    show(104);
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    check_all(105, 3'b001, 1, 0, 3'b001, 2'd0);
    show(105);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
